// File: rtl/rv32m_iter_mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per clock, with a one-cycle fast path for division special cases.
module rv32m_iter_mdu #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            wen_out
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN-1:0] acc_step;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, fin;
  logic              sgn_a, sgn_b;
  logic              op_sa, op_sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic              spec_div0, spec_ovf;

  // State and datapath registers; reset aborts any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // One iteration: acc holds {hi, lo} of the product, or {remainder, quotient}
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, ({XLEN{acc_q[0]}} & b_q)};
    div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, b_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN+1]) acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                   acc_step = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix-up of the final iteration's value into the architectural result
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -acc_step : acc_step;
    quo    = acc_step[XLEN-1:0];
    rem    = acc_step[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                fin = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin = prod_s[2*XLEN-1:XLEN];
      3'b100:                fin = (sa_q ^ sb_q) ? -quo : quo;
      3'b110:                fin = sa_q ? -rem : rem;
      3'b101:                fin = quo;
      default:               fin = rem;
    endcase
  end

  // Operand signedness per op, magnitudes and division special-case detection
  always_comb begin
    op_sa = 1'b0;
    op_sb = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin op_sa = 1'b1; op_sb = 1'b1; end
      3'b010:                         op_sa = 1'b1;
      default: ;
    endcase
    sgn_a     = op_sa & rs1_val[XLEN-1];
    sgn_b     = op_sb & rs2_val[XLEN-1];
    mag_a     = sgn_a ? -rs1_val : rs1_val;
    mag_b     = sgn_b ? -rs2_val : rs2_val;
    spec_div0 = funct3[2] && (rs2_val == '0);
    spec_ovf  = funct3[2] && !funct3[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = funct3;
          rd_d  = rd_in;
          sa_d  = sgn_a;
          sb_d  = sgn_b;
          b_d   = mag_b;
          acc_d = {{XLEN{1'b0}}, mag_a};
          cnt_d = '0;
          if (spec_div0) begin
            result_d = funct3[1] ? rs1_val : '1;
            state_d  = DONE;
          end else if (spec_ovf) begin
            result_d = funct3[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == '1) begin
          result_d = fin;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register-file style outputs
  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    result  = result_q;
    rd_out  = rd_q;
    wen_out = done && (rd_q != 5'd0);
  end

endmodule
